// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: md_op encodings, FSM state encoding and op-class helpers.
package md_unit_pkg;

    localparam int unsigned MD_OP_W   = 4;
    localparam int unsigned MD_DATA_W = 32;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_md_start(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath for the latched operands; div0 flags a divide by zero.
module md_compute
    import md_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0]   op_q,
    input  logic [MD_DATA_W-1:0] a_q,
    input  logic [MD_DATA_W-1:0] b_q,
    output logic [MD_DATA_W-1:0] res_hi,
    output logic [MD_DATA_W-1:0] res_lo,
    output logic                 div0
);

    logic signed [63:0]          prod_s;
    logic        [63:0]          prod_u;
    logic        [MD_DATA_W-1:0] b_nz;
    logic signed [32:0]          sa;
    logic signed [32:0]          sb;
    logic signed [32:0]          sq;
    logic signed [32:0]          sr;
    logic        [MD_DATA_W-1:0] uq;
    logic        [MD_DATA_W-1:0] ur;

    assign div0 = is_div_op(op_q) && (b_q == '0);

    // Divisor forced nonzero so the dividers never see zero; div0 blocks the commit instead.
    assign b_nz = (b_q == '0) ? 32'd1 : b_q;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // 33-bit signed divide keeps INT_MIN / -1 well defined (wraps to 0x80000000, remainder 0).
    assign sa = {a_q[31], a_q};
    assign sb = {b_nz[31], b_nz};
    assign sq = sa / sb;
    assign sr = sa % sb;
    assign uq = a_q / b_nz;
    assign ur = a_q % b_nz;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op_q)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_lo = 32'(sq);
                res_hi = 32'(sr);
            end
            MD_DIVU: begin
                res_lo = uq;
                res_hi = ur;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide controller: busy FSM, operand latches, HI/LO and MFHI/MFLO read port.
// Optional MD_FLUSH_EN adds a flush input that aborts the in-flight op and suppresses writes.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MD_OP_W-1:0]   md_op,
    input  logic [MD_DATA_W-1:0] a,
    input  logic [MD_DATA_W-1:0] b,
    input  logic                 md_req_D,
`ifdef MD_FLUSH_EN
    input  logic                 flush,
`endif
    output logic                 busy,
    output logic                 stall_md,
    output logic [MD_DATA_W-1:0] hi,
    output logic [MD_DATA_W-1:0] lo,
    output logic [MD_DATA_W-1:0] hilo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MD_OP_W-1:0]   op_q, op_d;
    logic [MD_DATA_W-1:0] a_q, a_d;
    logic [MD_DATA_W-1:0] b_q, b_d;
    logic [MD_DATA_W-1:0] hi_q, hi_d;
    logic [MD_DATA_W-1:0] lo_q, lo_d;
    logic [MD_DATA_W-1:0] res_hi, res_lo;
    logic                 div0;
    logic                 kill;

`ifdef MD_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    md_compute u_compute (
        .op_q   (op_q),
        .a_q    (a_q),
        .b_q    (b_q),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    // State, counter, operand latches and HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next state: accept/MTxx only when idle; commit on the last RUN cycle unless dividing by zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (kill) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_IDLE) begin
            if (start && is_md_start(md_op)) begin
                state_d = ST_RUN;
                op_d    = md_op;
                a_d     = a;
                b_d     = b;
                cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (md_op == MD_MTHI) begin
                hi_d = a;
            end else if (md_op == MD_MTLO) begin
                lo_d = a;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                if (!div0) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_md = md_req_D & (busy | start);

    // Read port reflects committed HI/LO only; no bypass from an in-flight result.
    always_comb begin
        hilo_out = '0;
        if (md_op == MD_MFHI) begin
            hilo_out = hi_q;
        end else if (md_op == MD_MFLO) begin
            hilo_out = lo_q;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed test-plan cases plus randomized ops against a reference model.
module tb_md_unit;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                           OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MFHI = 4'd7,
                           OP_MFLO = 4'd8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_req_D;
    logic        fl;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: committed HI/LO, cycles left busy, and the pending result.
    int          left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_div0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .md_req_D (md_req_D),
`ifdef MD_FLUSH_EN
        .flush    (fl),
`endif
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo),
        .hilo_out (hilo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic.
    task automatic calc(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] rh, output logic [31:0] rl, output bit dz);
        longint          sa, sb, sq, sr;
        longint unsigned pu;
        longint          ps;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        rh = '0;
        rl = '0;
        dz = 1'b0;
        case (op)
            OP_MULT: begin
                ps = sa * sb;
                rh = 32'(ps >>> 32);
                rl = 32'(ps);
            end
            OP_MULTU: begin
                pu = longint'({32'b0, av}) * longint'({32'b0, bv});
                rh = 32'(pu >> 32);
                rl = 32'(pu);
            end
            OP_DIV: begin
                if (bv == 0) dz = 1'b1;
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    rl = 32'(sq);
                    rh = 32'(sr);
                end
            end
            default: begin
                if (bv == 0) dz = 1'b1;
                else begin
                    rl = av / bv;
                    rh = av % bv;
                end
            end
        endcase
    endtask

    task automatic model_reset();
        left   = 0;
        m_hi   = '0;
        m_lo   = '0;
        p_hi   = '0;
        p_lo   = '0;
        p_div0 = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic [3:0] op, input logic [31:0] av,
                              input logic [31:0] bv, input logic f);
        bit fe;
`ifdef MD_FLUSH_EN
        fe = f;
`else
        fe = 1'b0;
        if (f) fe = 1'b0;
`endif
        if (fe) begin
            left = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0 && !p_div0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st && op >= OP_MULT && op <= OP_DIVU) begin
            left = (op >= OP_DIV) ? int'(DIV_N) : int'(MULT_N);
            calc(op, av, bv, p_hi, p_lo, p_div0);
        end else if (op == OP_MTHI) begin
            m_hi = av;
        end else if (op == OP_MTLO) begin
            m_lo = av;
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registered state.
    task automatic cyc(input logic st, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic rq);
        logic [31:0] exp_hilo;
        start    = st;
        md_op    = op;
        a        = av;
        b        = bv;
        md_req_D = rq;
        #1;
        exp_hilo = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
        check("stall_md", 32'(stall_md), 32'(rq & ((left > 0) | st)));
        check("hilo_out", hilo_out, exp_hilo);
        @(posedge clk);
        model_step(st, op, av, bv, fl);
        #1;
        check("busy", 32'(busy), 32'(left > 0));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic idle(input int n, input logic rq);
        for (int i = 0; i < n; i++) cyc(1'b0, OP_NONE, 32'd0, 32'd0, rq);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] edges [4];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
        return $urandom;
    endfunction

    initial begin
        int          nb;
        logic [3:0]  rop;
        logic        rst_start;
        reset    = 1'b1;
        start    = 1'b0;
        md_op    = OP_NONE;
        a        = '0;
        b        = '0;
        md_req_D = 1'b0;
        fl       = 1'b0;
        model_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // MULT -2 * 3 with D-stage stall request held; a start while busy must be ignored.
        cyc(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        nb = 0;
        if (busy) nb++;
        cyc(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
        if (busy) nb++;
        cyc(1'b1, OP_MULTU, 32'd9, 32'd9, 1'b1);
        if (busy) nb++;
        cyc(1'b0, OP_MTHI, 32'h1234_5678, 32'd0, 1'b1);
        if (busy) nb++;
        cyc(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
        if (busy) nb++;
        check("mult_busy_len", 32'(nb), 32'd5);
        cyc(1'b0, OP_MFHI, 32'd0, 32'd0, 1'b1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        cyc(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);

        // DIVU 100 / 7, then DIV -7 / 2.
        cyc(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        idle(DIV_N, 1'b0);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        cyc(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_N, 1'b0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // MTHI/MTLO preload, back-to-back MFLO, then divide by zero leaves HI/LO intact.
        cyc(1'b0, OP_MTHI, 32'h11, 32'd0, 1'b0);
        cyc(1'b0, OP_MTLO, 32'h22, 32'd0, 1'b0);
        cyc(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
        cyc(1'b1, OP_DIV, 32'd77, 32'd0, 1'b1);
        nb = 1;
        for (int i = 0; i < int'(DIV_N); i++) begin
            cyc(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
            if (busy) nb++;
        end
        check("div0_busy_len", 32'(nb), 32'(DIV_N));
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // Asynchronous reset in the middle of a DIV: cleared at once, no late commit.
        cyc(1'b0, OP_MTHI, 32'h55, 32'd0, 1'b0);
        cyc(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0);
        idle(3, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(DIV_N + 2, 1'b0);
        check("arst_no_commit_lo", lo, 32'd0);

`ifdef MD_FLUSH_EN
        // Flush on the third busy cycle of MULTU discards the result and the MTLO beside it.
        cyc(1'b0, OP_MTHI, 32'hAA, 32'd0, 1'b0);
        cyc(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle(2, 1'b0);
        fl = 1'b1;
        cyc(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        check("flush_busy", 32'(busy), 32'd0);
        cyc(1'b0, OP_MTLO, 32'hBB, 32'd0, 1'b0);
        fl = 1'b0;
        idle(MULT_N + 1, 1'b0);
        check("flush_hi", hi, 32'hAA);
        check("flush_lo", lo, 32'd0);
`endif

        // Randomized op stream against the model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 11))
                0, 1, 2: rop = OP_NONE;
                3:       rop = OP_MULT;
                4:       rop = OP_MULTU;
                5:       rop = OP_DIV;
                6:       rop = OP_DIVU;
                7:       rop = OP_MTHI;
                8:       rop = OP_MTLO;
                9:       rop = OP_MFHI;
                10:      rop = OP_MFLO;
                default: rop = OP_NONE;
            endcase
            rst_start = (rop >= OP_MULT && rop <= OP_DIVU);
            cyc(rst_start, rop, pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
